// File: rtl/lpc_cycle_decoder.sv
// Passive LPC snooper: one-clock record strobe per completed I/O/memory cycle, plus abort/timeout strobes.
// Record appears the clock after the last SYNC/data nibble; no backpressure (bus is observed only). LPC_DMA_EN adds DMA decode.
module lpc_cycle_decoder #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       MAX_WAIT = 64,
   parameter logic [ADDR_W-1:0] WIN_BASE = '0,
   parameter logic [ADDR_W-1:0] WIN_MASK = '0
) (
   input  logic              lpc_clock,
   input  logic              lpc_reset,
   input  logic              lpc_frame,
   input  logic [3:0]        lpc_ad,
   output logic              out_valid,
   output logic [3:0]        out_cyctype_dir,
   output logic [ADDR_W-1:0] out_addr,
   output logic [7:0]        out_data,
   output logic              out_sync_err,
   output logic              out_abort,
   output logic              out_timeout
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_CYC, S_ADDR, S_WDATA, S_TAR1, S_SYNC, S_RDATA, S_TAR2
   } state_t;

   typedef struct packed {
      logic [3:0]        cyctype_dir;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      logic              sync_err;
   } rec_t;

   localparam logic [8:0] WAIT_LIMIT = 9'(MAX_WAIT);

   state_t            state, state_n;
   logic [3:0]        start_code, start_code_n;
   logic [3:0]        cyc, cyc_n;
   logic [ADDR_W-1:0] addr_sr, addr_sr_n;
   logic [7:0]        data_sr, data_sr_n;
   logic [2:0]        nib_cnt, nib_cnt_n;
   logic              phase, phase_n;
   logic [7:0]        wait_cnt, wait_cnt_n;
   logic              err, err_n;
   rec_t              rec_q, rec_n;
   logic              valid_n, abort_n, timeout_n;
   logic              rec_done, win_hit, sync_ready, is_dma;
   logic [8:0]        wait_inc;

`ifdef LPC_DMA_EN
   assign is_dma = (cyc[3:2] == 2'b10);
`else
   assign is_dma = 1'b0;
`endif

   assign sync_ready = (lpc_ad == 4'b0000) || (is_dma && lpc_ad == 4'b1001);
   assign wait_inc   = {1'b0, wait_cnt} + 9'd1;
   // DMA records carry a channel, not an address, so they skip the window
   assign win_hit    = is_dma || ((addr_sr & WIN_MASK) == (WIN_BASE & WIN_MASK));

   always_comb begin
      state_n      = state;
      start_code_n = start_code;
      cyc_n        = cyc;
      addr_sr_n    = addr_sr;
      data_sr_n    = data_sr;
      nib_cnt_n    = nib_cnt;
      phase_n      = phase;
      wait_cnt_n   = wait_cnt;
      err_n        = err;
      rec_n        = rec_q;
      rec_done     = 1'b0;
      valid_n      = 1'b0;
      abort_n      = 1'b0;
      timeout_n    = 1'b0;

      if (!lpc_frame) begin
         state_n      = S_START;
         start_code_n = lpc_ad;
         abort_n      = state inside {S_CYC, S_ADDR, S_WDATA, S_TAR1, S_SYNC, S_RDATA};
      end else begin
         unique case (state)
            S_IDLE: ;
            S_START: begin
               state_n = S_IDLE;
               if (start_code == 4'b0000) begin
                  cyc_n     = lpc_ad;
                  addr_sr_n = '0;
                  data_sr_n = '0;
                  phase_n   = 1'b0;
                  err_n     = 1'b0;
                  case (lpc_ad[3:2])
                     2'b00: begin nib_cnt_n = 3'd3; state_n = S_ADDR; end
                     2'b01: begin nib_cnt_n = 3'd7; state_n = S_ADDR; end
`ifdef LPC_DMA_EN
                     2'b10: begin nib_cnt_n = 3'd0; state_n = S_ADDR; end
`endif
                     default: state_n = S_IDLE;
                  endcase
               end
            end
            S_ADDR: begin
               addr_sr_n = {addr_sr[ADDR_W-5:0], lpc_ad};
               nib_cnt_n = nib_cnt - 3'd1;
               if (nib_cnt == 3'd0)
                  state_n = is_dma ? S_CYC : (cyc[1] ? S_WDATA : S_TAR1);
            end
            // DMA size nibble: only 8-bit transfers are followed
            S_CYC: state_n = (lpc_ad[1:0] == 2'b00) ? S_TAR1 : S_IDLE;
            S_WDATA: begin
               if (!phase) data_sr_n[3:0] = lpc_ad;
               else        data_sr_n[7:4] = lpc_ad;
               phase_n = !phase;
               if (phase) state_n = S_TAR1;
            end
            S_TAR1: begin
               phase_n = !phase;
               if (phase) begin
                  state_n    = S_SYNC;
                  wait_cnt_n = '0;
               end
            end
            S_SYNC: begin
               if (sync_ready || lpc_ad == 4'b1010) begin
                  err_n = (lpc_ad == 4'b1010);
                  if (cyc[1] && !is_dma) begin
                     rec_done = 1'b1;
                     state_n  = S_TAR2;
                  end else begin
                     state_n = S_RDATA;
                  end
               end else if (lpc_ad == 4'b0101 || lpc_ad == 4'b0110) begin
                  wait_cnt_n = wait_inc[7:0];
                  if (wait_inc == WAIT_LIMIT) begin
                     timeout_n = 1'b1;
                     state_n   = S_IDLE;
                  end
               end else begin
                  state_n = S_IDLE;
               end
            end
            S_RDATA: begin
               if (!phase) data_sr_n[3:0] = lpc_ad;
               else        data_sr_n[7:4] = lpc_ad;
               phase_n = !phase;
               if (phase) begin
                  rec_done = 1'b1;
                  state_n  = S_TAR2;
               end
            end
            S_TAR2: begin
               phase_n = !phase;
               if (phase) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end

      // record fields only move when a record is actually reported
      if (rec_done && win_hit) begin
         valid_n = 1'b1;
         rec_n   = '{cyctype_dir: cyc, addr: addr_sr, data: data_sr_n, sync_err: err_n};
      end
   end

   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         state       <= S_IDLE;
         start_code  <= '0;
         cyc         <= '0;
         addr_sr     <= '0;
         data_sr     <= '0;
         nib_cnt     <= '0;
         phase       <= 1'b0;
         wait_cnt    <= '0;
         err         <= 1'b0;
         rec_q       <= '0;
         out_valid   <= 1'b0;
         out_abort   <= 1'b0;
         out_timeout <= 1'b0;
      end else begin
         state       <= state_n;
         start_code  <= start_code_n;
         cyc         <= cyc_n;
         addr_sr     <= addr_sr_n;
         data_sr     <= data_sr_n;
         nib_cnt     <= nib_cnt_n;
         phase       <= phase_n;
         wait_cnt    <= wait_cnt_n;
         err         <= err_n;
         rec_q       <= rec_n;
         out_valid   <= valid_n;
         out_abort   <= abort_n;
         out_timeout <= timeout_n;
      end
   end

   assign out_cyctype_dir = rec_q.cyctype_dir;
   assign out_addr        = rec_q.addr;
   assign out_data        = rec_q.data;
   assign out_sync_err    = rec_q.sync_err;

endmodule
